// File: rtl/aes_decrypt_iter.sv
// AES-128 inverse cipher: one round per clock through a shared inverse-round datapath,
// with an on-chip round-key store filled by forward key expansion and reusable across jobs.
module aes_decrypt_iter #(
  parameter int unsigned REUSE_KEY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertextin,
  input  logic [127:0] keyin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, KEYEXP, ADDK, ROUND, FINAL, DONE} fsm_t;

  fsm_t         fsm, fsm_next;
  logic [3:0]   r;
  logic [127:0] blk;
  logic [127:0] rk [0:10];
  logic         key_valid;
  logic         reuse;
  logic [127:0] round_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); also maps 0 to 0 as the S-box needs
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq, res;
    sq  = a;
    res = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      res = gmul(res, sq);
    end
    return res;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // InvShiftRows fused with InvSubBytes: row r rotates right by r columns
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned row = 0; row < 4; row++)
      for (int unsigned col = 0; col < 4; col++)
        o[127 - 8*(row + 4*col) -: 8] = inv_sbox(s[127 - 8*(row + 4*((col + 4 - row) % 4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned col = 0; col < 4; col++) begin
      a0 = s[127 - 32*col -: 8];
      a1 = s[119 - 32*col -: 8];
      a2 = s[111 - 32*col -: 8];
      a3 = s[103 - 32*col -: 8];
      o[127 - 32*col -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction

  assign reuse    = (REUSE_KEY != 0) && key_valid && (keyin == rk[0]);
  assign round_t  = inv_shift_sub(blk) ^ rk[r];
  assign in_ready = (fsm == IDLE);
  assign busy     = (fsm != IDLE);
  assign out_valid = (fsm == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE:    if (in_valid) fsm_next = reuse ? ADDK : KEYEXP;
      KEYEXP:  if (r == 4'd10) fsm_next = ADDK;
      ADDK:    fsm_next = ROUND;
      ROUND:   if (r == 4'd1) fsm_next = FINAL;
      FINAL:   fsm_next = DONE;
      DONE:    if (out_ready) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  // rk[0] doubles as the stored key; key_valid drops while it is being rewritten
  always_ff @(posedge clk) begin
    if (fsm == IDLE && in_valid && !reuse) rk[0] <= keyin;
    else if (fsm == KEYEXP)                rk[r] <= expand(rk[r - 4'd1], rcon(r));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r         <= '0;
      blk       <= '0;
      plaintext <= '0;
      key_valid <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          blk <= ciphertextin;
          r   <= 4'd1;
          if (!reuse) key_valid <= 1'b0;
        end
        KEYEXP: begin
          r <= r + 4'd1;
          if (r == 4'd10) key_valid <= 1'b1;
        end
        ADDK: begin
          blk <= blk ^ rk[10];
          r   <= 4'd9;
        end
        ROUND: begin
          blk <= inv_mix(round_t);
          r   <= r - 4'd1;
        end
        FINAL:   plaintext <= round_t;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed FIPS-197 vectors, key reuse, backpressure and reset-abort checks, then random
// blocks encrypted by a small forward AES model and decrypted by the DUT.
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertextin;
  logic [127:0] keyin;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         busy;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] sb [256];

  typedef struct {
    logic [127:0] ct;
    logic [127:0] key;
    logic [127:0] pt;
    int           lat;
  } vec_t;

  vec_t vecs [4];

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  aes_decrypt_iter #(.REUSE_KEY(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertextin(ciphertextin), .keyin(keyin), .out_valid(out_valid),
    .out_ready(out_ready), .plaintext(plaintext), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // forward S-box via the 3 / (1/3) generator walk
  task automatic build_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] rk [11];
    logic [127:0] s, t;
    logic [31:0]  w0, w1, w2, w3, tw;
    logic [7:0]   rc, a0, a1, a2, a3;
    rk[0] = key;
    rc = 8'h01;
    for (int unsigned i = 1; i <= 10; i++) begin
      w3 = rk[i-1][31:0];
      tw = {sb[w3[23:16]], sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]} ^ {rc, 24'h000000};
      w0 = rk[i-1][127:96] ^ tw;
      w1 = rk[i-1][95:64] ^ w0;
      w2 = rk[i-1][63:32] ^ w1;
      w3 = w3 ^ w2;
      rk[i] = {w0, w1, w2, w3};
      rc = xt(rc);
    end
    s = pt ^ rk[0];
    for (int unsigned rd = 1; rd <= 10; rd++) begin
      t = '0;
      for (int unsigned i = 0; i < 16; i++) t[127 - 8*i -: 8] = sb[s[127 - 8*i -: 8]];
      for (int unsigned row = 0; row < 4; row++)
        for (int unsigned col = 0; col < 4; col++)
          s[127 - 8*(row + 4*col) -: 8] = t[127 - 8*(row + 4*((col + row) % 4)) -: 8];
      if (rd < 10) begin
        for (int unsigned col = 0; col < 4; col++) begin
          a0 = s[127 - 32*col -: 8];
          a1 = s[119 - 32*col -: 8];
          a2 = s[111 - 32*col -: 8];
          a3 = s[103 - 32*col -: 8];
          s[127 - 32*col -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                   xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
      end
      s = s ^ rk[rd];
    end
    return s;
  endfunction

  // start a job, count edges from accept to out_valid, then let out_ready complete it
  task automatic run_job(input logic [127:0] c, input logic [127:0] k, input logic [127:0] p,
                         input int lat, input string nm);
    int n;
    bit seen;
    @(negedge clk);
    chk({nm, "_in_ready_idle"}, 128'(in_ready), 128'd1);
    ciphertextin = c;
    keyin        = k;
    in_valid     = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({nm, "_in_ready_busy"}, 128'(in_ready), 128'd0);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) seen = 1'b1;
    end
    chk({nm, "_latency"}, 128'(n), 128'(lat));
    chk({nm, "_plaintext"}, plaintext, p);
    if (seen) begin
      @(posedge clk);
      #1;
      chk({nm, "_in_ready_after"}, 128'(in_ready), 128'd1);
      chk({nm, "_out_valid_after"}, 128'(out_valid), 128'd0);
    end
  endtask

  initial begin
    logic [127:0] rk_key, rpt, rct, prev_key;
    bit           model_valid;
    int           n;
    bit           seen;

    build_sbox();
    vecs[0] = '{ct: C1, key: K1, pt: P1, lat: 21};
    vecs[1] = '{ct: C2, key: K2, pt: P2, lat: 21};
    vecs[2] = '{ct: C2, key: K2, pt: P2, lat: 11};
    vecs[3] = '{ct: C1, key: K1, pt: P1, lat: 21};

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    ciphertextin = '0;
    keyin        = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_plaintext", plaintext, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++)
      run_job(vecs[i].ct, vecs[i].key, vecs[i].pt, vecs[i].lat, $sformatf("vec%0d", i));

    // backpressure: stored key is K1, so this job takes the reuse path
    out_ready = 1'b0;
    @(negedge clk);
    ciphertextin = C1;
    keyin        = K1;
    in_valid     = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) seen = 1'b1;
    end
    chk("bp_latency", 128'(n), 128'd11);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      in_valid = (i == 20);
      ciphertextin = C2;
      keyin        = K2;
      @(posedge clk);
      #1;
      chk($sformatf("bp_out_valid_%0d", i), 128'(out_valid), 128'd1);
      chk($sformatf("bp_plaintext_%0d", i), plaintext, P1);
      chk($sformatf("bp_in_ready_%0d", i), 128'(in_ready), 128'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);
    chk("bp_release_out_valid", 128'(out_valid), 128'd0);
    @(posedge clk);
    #1;
    chk("bp_pulse_not_queued", 128'(busy), 128'd0);

    // reset at T+15 while a K2 expansion job is in ROUND; store must be invalidated
    @(negedge clk);
    ciphertextin = C2;
    keyin        = K2;
    in_valid     = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    chk("abort_busy_pre", 128'(busy), 128'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    chk("abort_busy", 128'(busy), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(C2, K2, P2, 21, "after_abort");

    prev_key    = K2;
    model_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      rk_key = (i % 3 == 0) ? {$urandom, $urandom, $urandom, $urandom} : prev_key;
      rpt    = {$urandom, $urandom, $urandom, $urandom};
      rct    = encrypt(rpt, rk_key);
      run_job(rct, rk_key, rpt, (model_valid && rk_key == prev_key) ? 11 : 21,
              $sformatf("rand%0d", i));
      prev_key    = rk_key;
      model_valid = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
